microwave_timer_ctrl: RTL and testbench

- Controller for the microwave cook timer. It takes keypad digits, loads and sequences a three-digit countdown (M:SS) built from cascaded down-counting BCD digit stages, and divides the system clock into 1 s ticks.
- Runs the cook state machine (idle, entry, run, pause, done) and drives the magnetron enable.
- Sits between keypad/door inputs and the display and magnetron driver.

---
 rtl/microwave_timer_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: microwave cook-timer controller.
// Keypad digit entry into an M:SS BCD register, a 1 s prescaler, the
// IDLE/ENTRY/RUN/PAUSE/DONE cook state machine and the magnetron enable.
// Optional feature: define ADD30_EN to make start while cooking add 30 s
// (BCD carry, saturating at 9:59); otherwise start in RUN is ignored.
module microwave_timer_ctrl #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned QUICK_SECS = 30,
    parameter int unsigned BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clr,
    input  logic       door_closed,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] state,
    output logic       mag_on,
    output logic       done,
    output logic       key_err
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;

    // Quick-start time split into BCD digits {min, tens, ones}
    localparam int unsigned Q_MIN  = QUICK_SECS / 60;
    localparam int unsigned Q_TENS = (QUICK_SECS % 60) / 10;
    localparam int unsigned Q_ONES = QUICK_SECS % 10;
    localparam logic [11:0] QUICK_BCD = {4'(Q_MIN), 4'(Q_TENS), 4'(Q_ONES)};

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          cur_st, nxt_st;
    logic [11:0]     cur_time, nxt_time;   // {min_ones, sec_tens, sec_ones}
    logic [PW-1:0]   presc, nxt_presc;
    logic [BW-1:0]   beep, nxt_beep;
    logic            kerr, nxt_kerr;

    logic            tick;
    logic [PW-1:0]   presc_inc;
    logic [BW-1:0]   beep_inc;
    logic [11:0]     dec_time;
    logic [11:0]     run_time;
    logic            time_zero;
    logic            key_bad;

    // One-second BCD decrement of M:SS; only applied to a nonzero time
    function automatic logic [11:0] bcd_dec(input logic [11:0] t);
        logic [3:0] m, tn, o;
        m  = t[11:8];
        tn = t[7:4];
        o  = t[3:0];
        if (o != 4'd0) begin
            o = o - 4'd1;
        end else begin
            o = 4'd9;
            if (tn != 4'd0) begin
                tn = tn - 4'd1;
            end else begin
                tn = 4'd5;
                m  = m - 4'd1;
            end
        end
        return {m, tn, o};
    endfunction

`ifdef ADD30_EN
    // Add 30 s: only the tens digit moves, carrying into minutes; clamp at 9:59
    function automatic logic [11:0] bcd_add30(input logic [11:0] t);
        logic [3:0] m, tn, o;
        m  = t[11:8];
        tn = t[7:4] + 4'd3;
        o  = t[3:0];
        if (tn > 4'd5) begin
            tn = tn - 4'd6;
            if (m == 4'd9) begin
                return {4'd9, 4'd5, 4'd9};
            end
            m = m + 4'd1;
        end
        return {m, tn, o};
    endfunction
`endif

    assign tick      = (presc == PRESC_LAST);
    assign presc_inc = tick ? '0 : presc + PW'(1);
    assign beep_inc  = beep + BW'(1);
    assign dec_time  = bcd_dec(cur_time);
    assign time_zero = (cur_time == '0);
    // A key is refused if it is not a digit or would shift >5 into the tens
    assign key_bad   = (key_digit > 4'd9) || (cur_time[3:0] > 4'd5);

    // Time seen by RUN this cycle: decremented on tick, optionally bumped by start
    always_comb begin
        run_time = tick ? dec_time : cur_time;
`ifdef ADD30_EN
        if (start) begin
            run_time = bcd_add30(run_time);
        end
`endif
    end

    // Next-state and datapath decode; priority stop_clr > door > start > key
    always_comb begin
        nxt_st    = cur_st;
        nxt_time  = cur_time;
        nxt_presc = presc;
        nxt_beep  = beep;
        nxt_kerr  = 1'b0;
        case (cur_st)
            S_IDLE, S_ENTRY: begin
                if (stop_clr) begin
                    nxt_time = '0;
                    nxt_st   = S_IDLE;
                end else if (start) begin
                    if (cur_st == S_IDLE) begin
                        if (door_closed) begin
                            nxt_time  = QUICK_BCD;
                            nxt_presc = '0;
                            nxt_st    = S_RUN;
                        end
                    end else if (!time_zero && door_closed) begin
                        nxt_presc = '0;
                        nxt_st    = S_RUN;
                    end
                end else if (key_valid) begin
                    if (key_bad) begin
                        nxt_kerr = 1'b1;
                    end else begin
                        nxt_time = {cur_time[7:0], key_digit};
                        nxt_st   = S_ENTRY;
                    end
                end
            end
            S_RUN: begin
                // Stop or open door freezes prescaler and digits, even on a tick
                if (stop_clr || !door_closed) begin
                    nxt_st = S_PAUSE;
                end else begin
                    nxt_presc = presc_inc;
                    nxt_time  = run_time;
                    if (tick && run_time == '0) begin
                        nxt_beep = '0;
                        nxt_st   = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (stop_clr) begin
                    nxt_time = '0;
                    nxt_st   = S_IDLE;
                end else if (start && door_closed) begin
                    nxt_st = S_RUN;
                end
            end
            S_DONE: begin
                if (stop_clr || !door_closed) begin
                    nxt_st = S_IDLE;
                end else begin
                    nxt_presc = presc_inc;
                    if (tick) begin
                        nxt_beep = beep_inc;
                        if (beep_inc == BEEP_LAST) begin
                            nxt_st = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                nxt_time = '0;
                nxt_st   = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            cur_st <= S_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Digits, prescaler, beep counter and key error pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            cur_time <= '0;
            presc    <= '0;
            beep     <= '0;
            kerr     <= 1'b0;
        end else begin
            cur_time <= nxt_time;
            presc    <= nxt_presc;
            beep     <= nxt_beep;
            kerr     <= nxt_kerr;
        end
    end

    assign min_ones = cur_time[11:8];
    assign sec_tens = cur_time[7:4];
    assign sec_ones = cur_time[3:0];
    assign state    = cur_st;
    assign mag_on   = (cur_st == S_RUN) && door_closed;
    assign done     = (cur_st == S_DONE);
    assign key_err  = kerr;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with TICK_DIV=4, QUICK_SECS=30,
// BEEP_TICKS=3. Honors ADD30_EN to pick the expected start-in-RUN result.
module tb_microwave_timer_ctrl;

    logic       clk;
    logic       clr;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clr;
    logic       door_closed;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] state;
    logic       mag_on;
    logic       done;
    logic       key_err;

    int n_cmp = 0;
    int n_bad = 0;

    microwave_timer_ctrl #(
        .TICK_DIV  (4),
        .QUICK_SECS(30),
        .BEEP_TICKS(3)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .start      (start),
        .stop_clr   (stop_clr),
        .door_closed(door_closed),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .state      (state),
        .mag_on     (mag_on),
        .done       (done),
        .key_err    (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int m, input int t, input int o);
        chk({tag, ".min"},  int'(min_ones), m);
        chk({tag, ".tens"}, int'(sec_tens), t);
        chk({tag, ".ones"}, int'(sec_ones), o);
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic press_stop();
        stop_clr = 1'b1;
        step();
        stop_clr = 1'b0;
    endtask

    initial begin
        clr         = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        start       = 1'b0;
        stop_clr    = 1'b0;
        door_closed = 1'b1;
        step();
        step();
        clr = 1'b0;
        chk("rst.state", int'(state), 0);
        chk_time("rst", 0, 0, 0);
        chk("rst.mag", int'(mag_on), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.kerr", int'(key_err), 0);

        // Entry 1:25 and countdown with borrow
        press_key(4'd1);
        chk_time("k1", 0, 0, 1);
        chk("k1.state", int'(state), 1);
        press_key(4'd2);
        press_key(4'd5);
        chk_time("k125", 1, 2, 5);
        press_start();
        chk("run.state", int'(state), 2);
        chk("run.mag", int'(mag_on), 1);
        repeat (3) step();
        chk_time("pretick", 1, 2, 5);
        step();
        chk_time("tick1", 1, 2, 4);
        repeat (100) step();
        chk_time("borrow", 0, 5, 9);
        chk("borrow.state", int'(state), 2);
        press_stop();
        chk("stop.state", int'(state), 3);
        chk_time("stop", 0, 5, 9);
        chk("stop.mag", int'(mag_on), 0);
        press_stop();
        chk("clr.state", int'(state), 0);
        chk_time("clr", 0, 0, 0);

        // Door pause, resume with held prescaler, done and beep timeout
        press_key(4'd3);
        chk_time("k3", 0, 0, 3);
        press_start();
        repeat (4) step();
        chk_time("d.tick", 0, 0, 2);
        repeat (2) step();
        door_closed = 1'b0;
        #1;
        chk("door.mag", int'(mag_on), 0);
        chk("door.state", int'(state), 2);
        step();
        chk("pause.state", int'(state), 3);
        repeat (20) step();
        chk_time("pause.hold", 0, 0, 2);
        chk("pause.state2", int'(state), 3);
        door_closed = 1'b1;
        step();
        chk("closed.state", int'(state), 3);
        press_start();
        chk("resume.state", int'(state), 2);
        step();
        chk_time("resume.p3", 0, 0, 2);
        step();
        chk_time("resume.tick", 0, 0, 1);
        repeat (3) step();
        chk_time("pre0", 0, 0, 1);
        step();
        chk_time("zero", 0, 0, 0);
        chk("done.state", int'(state), 4);
        chk("done.done", int'(done), 1);
        chk("done.mag", int'(mag_on), 0);
        repeat (11) step();
        chk("beep.state", int'(state), 4);
        step();
        chk("beepend.state", int'(state), 0);
        chk("beepend.done", int'(done), 0);

        // Rejected keys
        press_key(4'd7);
        chk_time("k7", 0, 0, 7);
        chk("k7.kerr", int'(key_err), 0);
        press_key(4'd3);
        chk("rej.kerr", int'(key_err), 1);
        chk_time("rej", 0, 0, 7);
        chk("rej.state", int'(state), 1);
        step();
        chk("rej.kerr0", int'(key_err), 0);
        press_stop();
        chk("eclr.state", int'(state), 0);
        press_key(4'd10);
        chk("k10.kerr", int'(key_err), 1);
        chk_time("k10", 0, 0, 0);
        chk("k10.state", int'(state), 0);
        step();
        chk("k10.kerr0", int'(key_err), 0);

        // Quick start, stop beats start, start with door open
        press_start();
        chk("quick.state", int'(state), 2);
        chk_time("quick", 0, 3, 0);
        start    = 1'b1;
        stop_clr = 1'b1;
        step();
        start    = 1'b0;
        stop_clr = 1'b0;
        chk("prio.state", int'(state), 3);
        chk_time("prio", 0, 3, 0);
        press_stop();
        chk("qclr.state", int'(state), 0);
        door_closed = 1'b0;
        press_start();
        chk("open.state", int'(state), 0);
        chk_time("open", 0, 0, 0);
        door_closed = 1'b1;

        // Start while running
        press_key(4'd1);
        press_key(4'd4);
        press_key(4'd0);
        chk_time("k140", 1, 4, 0);
        press_start();
        press_start();
        chk("add.state", int'(state), 2);
`ifdef ADD30_EN
        chk_time("add30", 2, 1, 0);
`else
        chk_time("noadd", 1, 4, 0);
`endif
        press_stop();
        press_stop();
`ifdef ADD30_EN
        press_key(4'd5);
        press_key(4'd4);
        press_key(4'd7);
        chk_time("k547", 5, 4, 7);
        press_start();
        repeat (8) press_start();
        chk_time("at945", 9, 4, 5);
        press_start();
        chk_time("sat", 9, 5, 9);
        press_stop();
        press_stop();
`endif
        chk("end.state", int'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
